// File: rtl/sensor_hub.sv
// sensor_hub: multi-channel DHT11 request decoder with
// round-robin periodic temperature/humidity monitoring.
module sensor_hub #(
  parameter int NUM_CHANNELS   = 8,
  parameter int CH_W           = 3,
  parameter int MONITOR_PERIOD = 100000000,
  parameter int READ_TIMEOUT   = 5000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      request_valid,
  input  logic [7:0]                request,
  input  logic [7:0]                request_channel,
  output logic                      busy,
  output logic                      response_valid,
  output logic [7:0]                response,
  output logic [7:0]                response_code,
  output logic [7:0]                response_channel,
  output logic [NUM_CHANNELS-1:0]   sensor_enable,
  input  logic                      sensor_done,
  input  logic                      sensor_error,
  input  logic [39:0]               sensor_data,
  output logic [2*NUM_CHANNELS-1:0] monitor_active
);

  localparam int MW = 2 * NUM_CHANNELS;
  localparam int PW = $clog2(MW);
  localparam logic [7:0] NCH = 8'(NUM_CHANNELS);
  localparam logic [31:0] PER_LAST = 32'(MONITOR_PERIOD - 1);
  localparam logic [31:0] TMO_LAST = 32'(READ_TIMEOUT - 1);
  localparam logic [7:0] P_OK   = 8'hDF;
  localparam logic [7:0] P_ERR  = 8'hDE;
  localparam logic [7:0] P_CONF = 8'hCA;
  localparam logic [7:0] P_INV  = 8'hEA;
  localparam logic [7:0] P_UCMD = 8'hEC;
  localparam logic [7:0] P_UDEV = 8'hED;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    RESPOND,
    MON_READ
  } state_t;

  state_t         state;
  logic [7:0]     req_q;
  logic [7:0]     ch_q;
  logic [7:0]     pend_code;
  logic [7:0]     pend_payload;
  logic [31:0]    period_cnt;
  logic [31:0]    tmo_cnt;
  logic           tick_pending;
  logic [PW-1:0]  rr_ptr;
  logic [MW-1:0]  mon;

  logic [7:0]     sum;
  logic [7:0]     value;
  logic           read_ok;
  logic           read_done;
  logic           any_mon;
  logic           mon_wrap;
  logic [CH_W:0]  mbit;
  logic [PW-1:0]  pick;
  logic           found;
  int             idx;

  assign sum = sensor_data[39:32] + sensor_data[31:24]
             + sensor_data[23:16] + sensor_data[15:8];
  assign read_ok = sensor_done && !sensor_error
                && (sum == sensor_data[7:0]);
  assign read_done = sensor_done || (tmo_cnt == TMO_LAST);
  assign value = (req_q == 8'h02) ? sensor_data[39:32]
                                  : sensor_data[23:16];
  assign mbit = {ch_q[CH_W-1:0],
                 (req_q == 8'h04) || (req_q == 8'h06)};
  assign any_mon  = |mon;
  assign mon_wrap = any_mon && (period_cnt == PER_LAST);
  assign busy = (state != IDLE);
  assign monitor_active = mon;

  // first set monitor bit strictly after rr_ptr, wrapping
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= MW; i++) begin
      idx = (int'(rr_ptr) + i) % MW;
      if (!found && mon[PW'(idx)]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      req_q            <= '0;
      ch_q             <= '0;
      pend_code        <= '0;
      pend_payload     <= '0;
      period_cnt       <= '0;
      tmo_cnt          <= '0;
      tick_pending     <= 1'b0;
      rr_ptr           <= '0;
      mon              <= '0;
      sensor_enable    <= '0;
      response_valid   <= 1'b0;
      response         <= '0;
      response_code    <= '0;
      response_channel <= '0;
    end else begin
      response_valid <= 1'b0;

      if (!any_mon) begin
        period_cnt   <= '0;
        tick_pending <= 1'b0;
      end else if (mon_wrap) begin
        period_cnt   <= '0;
        tick_pending <= 1'b1;
      end else begin
        period_cnt <= period_cnt + 32'd1;
      end

      unique case (state)
        IDLE: begin
          if (request_valid) begin
            req_q <= request;
            ch_q  <= request_channel;
            state <= DECODE;
          end else if (tick_pending && any_mon) begin
            tick_pending  <= mon_wrap;
            rr_ptr        <= pick;
            ch_q          <= 8'(pick >> 1);
            req_q         <= pick[0] ? 8'h02 : 8'h01;
            sensor_enable <= NUM_CHANNELS'(1) << (pick >> 1);
            tmo_cnt       <= '0;
            state         <= MON_READ;
          end
        end
        DECODE: begin
          state        <= RESPOND;
          pend_code    <= 8'hEC;
          pend_payload <= P_UCMD;
          if (ch_q >= NCH) begin
            pend_code    <= req_q;
            pend_payload <= P_UDEV;
          end else begin
            case (req_q)
              8'h00, 8'h01, 8'h02: begin
                sensor_enable <= NUM_CHANNELS'(1) << ch_q[CH_W-1:0];
                tmo_cnt       <= '0;
                state         <= READ;
              end
              8'h03, 8'h04: begin
                pend_code    <= 8'h10 + req_q;
                pend_payload <= mon[mbit] ? P_INV : P_CONF;
                mon[mbit]    <= 1'b1;
              end
              8'h05, 8'h06: begin
                pend_code    <= 8'h10 + req_q;
                pend_payload <= mon[mbit] ? P_CONF : P_INV;
                mon[mbit]    <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        READ, MON_READ: begin
          if (read_done) begin
            sensor_enable <= '0;
            state         <= RESPOND;
            if (req_q == 8'h00) begin
              pend_code    <= 8'h10;
              pend_payload <= read_ok ? P_OK : P_ERR;
            end else if (read_ok) begin
              pend_code    <= 8'h10 + req_q;
              pend_payload <= value;
            end else begin
              pend_code    <= P_ERR;
              pend_payload <= req_q;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        RESPOND: begin
          response_valid   <= 1'b1;
          response         <= pend_payload;
          response_code    <= pend_code;
          response_channel <= ch_q;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
